// File: rtl/ppu_pkg.sv
// Shared posit packing configuration: widths derived from N/ES, NaR constant, S1->S2 payload.
// Define NO_ES_FIELD for an ES==0 build (removes the exponent field entirely).
package ppu_pkg;

    localparam int N = 16;
`ifdef NO_ES_FIELD
    localparam int ES = 0;
`else
    localparam int ES = 1;
`endif
    localparam int ES_W         = (ES > 0) ? ES : 1;
    localparam int K_SIZE       = $clog2(N - 1) + 1;
    localparam int MANT_SIZE    = N - 3 - ES;
    localparam int REG_LEN_SIZE = $clog2(N + 1);

    function automatic logic [N-1:0] nar(input int n);
        return N'(1) << (n - 1);
    endfunction

    typedef struct packed {
        logic [N-2:0] body;
        logic         sign;
        logic         is_zero;
        logic         is_nar;
        logic         rnd;
        logic         stk;
        logic         oob;
        logic         k_pos;
        logic         k_neg;
    } s1_payload_t;

endpackage

// File: rtl/posit_body_assemble.sv
// Combinational regime/exponent/fraction assembly into the N-1 bit posit body.
// Zero latency; no flow control of its own.
// Purely combinational, so backpressure is handled entirely by the enclosing pipeline.
module posit_body_assemble
    import ppu_pkg::*;
(
    input  logic [K_SIZE-1:0]    k,
    input  logic [ES_W-1:0]      next_exp,
    input  logic [MANT_SIZE-1:0] frac,
    input  logic                 frac_en,
    output logic [N-2:0]         body
);

    int           kv;
    int           reg_len;
    int           pos;
    logic         run;
    logic [ES_W-1:0] exp_sh;
    logic [N-2:0] frac_ext;

    always_comb begin
        kv       = int'($signed(k));
        run      = !k[K_SIZE-1];
        reg_len  = run ? kv + 2 : 1 - kv;
        frac_ext = frac_en ? {{(N - 1 - MANT_SIZE){1'b0}}, frac} : '0;
        body     = '0;
        pos      = 0;
        exp_sh   = '0;
        // pos counts from the MSB; pattern bits past bit 0 simply fall off the end
        for (int i = 0; i < N - 1; i++) begin
            pos = N - 2 - i;
            if (pos < reg_len - 1) begin
                body[i] = run;
            end else if (pos == reg_len - 1) begin
                body[i] = !run;
            end else if (pos < reg_len + ES) begin
                exp_sh  = next_exp << (pos - reg_len);
                body[i] = exp_sh[ES_W-1];
            end else begin
                body[i] = frac_ext[i];
            end
        end
    end

endmodule

// File: rtl/posit_round_pack.sv
// Posit round/pack: assembles the body (S1), rounds to nearest even with saturation and applies sign (S2).
// Latency 2 cycles, 1/cycle throughput; output held stable while out_valid & !out_ready.
// Backpressure: each stage loads when empty or draining; ROUND_PACK_STATS_EN adds round-up/saturation counters.
module posit_round_pack
    import ppu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 sign,
    input  logic                 is_zero,
    input  logic                 is_nar,
    input  logic [K_SIZE-1:0]    k,
`ifndef NO_ES_FIELD
    input  logic [ES-1:0]        next_exp,
`endif
    input  logic [MANT_SIZE-1:0] frac,
    input  logic                 round_bit,
    input  logic                 sticky_bit,
    input  logic                 k_is_oob,
    input  logic                 non_zero_frac_field_size,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N-1:0]         posit
`ifdef ROUND_PACK_STATS_EN
    ,
    input  logic                 stats_clr,
    output logic [15:0]          cnt_round_up,
    output logic [15:0]          cnt_sat
`endif
);

    logic            s1_v, s2_v, s1_load, s2_load;
    logic [ES_W-1:0] exp_int;
    logic [N-2:0]    asm_body;
    s1_payload_t     s1_d, s1_q;
    logic [N-1:0]    posit_q;

`ifdef NO_ES_FIELD
    assign exp_int = '0;
`else
    assign exp_int = next_exp;
`endif

    posit_body_assemble u_asm (
        .k        (k),
        .next_exp (exp_int),
        .frac     (frac),
        .frac_en  (non_zero_frac_field_size),
        .body     (asm_body)
    );

    assign s2_load  = !s2_v || out_ready;
    assign s1_load  = !s1_v || s2_load;
    assign in_ready = s1_load;

    always_comb begin
        s1_d.body    = asm_body;
        s1_d.sign    = sign;
        s1_d.is_zero = is_zero;
        s1_d.is_nar  = is_nar;
        s1_d.rnd     = round_bit;
        s1_d.stk     = sticky_bit;
        s1_d.oob     = k_is_oob;
        s1_d.k_pos   = !k[K_SIZE-1] && (k != '0);
        s1_d.k_neg   = k[K_SIZE-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v <= 1'b0;
            s1_q <= '0;
        end else if (s1_load) begin
            s1_v <= in_valid;
            if (in_valid) s1_q <= s1_d;
        end
    end

    logic         inc;
    logic [N-2:0] body_sat, body_rnd;
    logic [N-1:0] u, res;

    always_comb begin
        body_sat = s1_q.body;
        if (s1_q.oob && s1_q.k_pos)      body_sat = '1;
        else if (s1_q.oob && s1_q.k_neg) body_sat = (N-1)'(1);
        // all-ones body must not carry into the NaR pattern
        inc      = s1_q.rnd && (s1_q.stk || s1_q.body[0]) && !s1_q.oob && !(&s1_q.body);
        body_rnd = body_sat + (N-1)'(inc);
        if (body_rnd == '0) body_rnd = (N-1)'(1);
        u   = {1'b0, body_rnd};
        res = s1_q.sign ? -u : u;
        if (s1_q.is_nar)       res = nar(N);
        else if (s1_q.is_zero) res = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v    <= 1'b0;
            posit_q <= '0;
        end else if (s2_load) begin
            s2_v <= s1_v;
            if (s1_v) posit_q <= res;
        end
    end

    assign out_valid = s2_v;
    assign posit     = posit_q;

`ifdef ROUND_PACK_STATS_EN
    logic s2_inc, s2_oob;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_inc       <= 1'b0;
            s2_oob       <= 1'b0;
            cnt_round_up <= '0;
            cnt_sat      <= '0;
        end else begin
            if (s2_load && s1_v) begin
                s2_inc <= inc && !s1_q.is_nar && !s1_q.is_zero;
                s2_oob <= s1_q.oob;
            end
            if (stats_clr) begin
                cnt_round_up <= '0;
                cnt_sat      <= '0;
            end else if (s2_v && out_ready) begin
                if (s2_inc && cnt_round_up != 16'hFFFF) cnt_round_up <= cnt_round_up + 16'd1;
                if (s2_oob && cnt_sat != 16'hFFFF)      cnt_sat      <= cnt_sat + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_posit_round_pack.sv
// Scoreboard bench for posit_round_pack: directed corner cases plus random fields against a bit-list reference model.
module tb_posit_round_pack;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic        sign, is_zero, is_nar;
    logic [4:0]  k;
    logic [0:0]  next_exp;
    logic [11:0] frac;
    logic        round_bit, sticky_bit, k_is_oob, non_zero_frac_field_size;
    logic        out_valid, out_ready;
    logic [15:0] posit;

    posit_round_pack dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .in_valid                 (in_valid),
        .in_ready                 (in_ready),
        .sign                     (sign),
        .is_zero                  (is_zero),
        .is_nar                   (is_nar),
        .k                        (k),
        .next_exp                 (next_exp),
        .frac                     (frac),
        .round_bit                (round_bit),
        .sticky_bit               (sticky_bit),
        .k_is_oob                 (k_is_oob),
        .non_zero_frac_field_size (non_zero_frac_field_size),
        .out_valid                (out_valid),
        .out_ready                (out_ready),
        .posit                    (posit)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        sign, zero, nar;
        int        k;
        bit        exp;
        bit [11:0] frac;
        bit        rnd, stk, oob, nzf;
    } stim_t;

    logic [15:0] sbq[$];
    int vectors = 0;
    int miscompares = 0;
    int mode = 0;   // 0: ready=1, 1: toggle, 2: random, 3: ready=0

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: lay the fields out as a list of bits, keep the first 15, then round.
    function automatic logic [15:0] model(input stim_t s);
        bit q[$];
        int body, rl, fl;
        if (s.nar)  return 16'h8000;
        if (s.zero) return 16'h0000;
        if (s.k >= 0) begin
            repeat (s.k + 1) q.push_back(1'b1);
            q.push_back(1'b0);
            rl = s.k + 2;
        end else begin
            repeat (-s.k) q.push_back(1'b0);
            q.push_back(1'b1);
            rl = 1 - s.k;
        end
        q.push_back(s.exp);
        fl = 14 - rl;
        for (int j = fl - 1; j >= 0; j--) q.push_back(s.nzf ? s.frac[j] : 1'b0);
        body = 0;
        for (int i = 0; i < 15; i++) body = body * 2 + ((i < q.size()) ? int'(q[i]) : 0);
        if (s.oob) begin
            body = (s.k > 0) ? 32767 : 1;
        end else if (s.rnd && (s.stk || (body % 2 == 1)) && body != 32767) begin
            body = body + 1;
        end
        if (body == 0) body = 1;
        return s.sign ? 16'(65536 - body) : 16'(body);
    endfunction

    function automatic stim_t mk(bit sg, bit z, bit na, int kk, bit e, bit [11:0] f,
                                 bit r, bit st, bit o, bit nz);
        stim_t s;
        s.sign = sg; s.zero = z; s.nar = na; s.k = kk; s.exp = e; s.frac = f;
        s.rnd = r; s.stk = st; s.oob = o; s.nzf = nz;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        int rl;
        s.nar  = ($urandom_range(0, 19) == 0);
        s.zero = ($urandom_range(0, 14) == 0);
        s.oob  = ($urandom_range(0, 9) == 0);
        if (s.oob) s.k = ($urandom_range(0, 1) == 1) ? 14 : -14;
        else       s.k = int'($urandom_range(0, 26)) - 13;
        rl     = (s.k >= 0) ? s.k + 2 : 1 - s.k;
        s.nzf  = (14 - rl) >= 0;
        s.sign = 1'($urandom);
        s.exp  = 1'($urandom);
        s.frac = 12'($urandom);
        s.rnd  = 1'($urandom);
        s.stk  = 1'($urandom);
        return s;
    endfunction

    task automatic drive_ready();
        case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            2:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    endtask

    task automatic apply(input stim_t s);
        sign = s.sign; is_zero = s.zero; is_nar = s.nar; k = 5'(s.k);
        next_exp = s.exp; frac = s.frac; round_bit = s.rnd; sticky_bit = s.stk;
        k_is_oob = s.oob; non_zero_frac_field_size = s.nzf;
    endtask

    // Holds the transaction until in_ready is seen; the following posedge accepts it.
    task automatic send(input stim_t s, input logic [15:0] exp_posit);
        int guard = 0;
        @(negedge clk);
        drive_ready();
        apply(s);
        in_valid = 1'b1;
        forever begin
            #1;
            if (in_ready) break;
            guard++;
            if (guard > 200) begin
                check("accept_timeout", 32'(in_ready), 32'd1);
                return;
            end
            @(negedge clk);
            drive_ready();
        end
        sbq.push_back(exp_posit);
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        drive_ready();
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int g = 0;
        while (sbq.size() != 0 && g < 500) begin
            idle_cycle();
            g++;
        end
        repeat (3) idle_cycle();
        check("drain", 32'(sbq.size()), 32'd0);
    endtask

    // Monitor: pops on every handshake and checks hold-stability across stalls.
    initial begin
        logic        stalled;
        logic [15:0] stall_val;
        logic [15:0] e;
        stalled = 1'b0;
        stall_val = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                stalled = 1'b0;
                continue;
            end
            if (stalled) check("stall_hold", {15'd0, out_valid, posit}, {15'd0, 1'b1, stall_val});
            if (out_valid) begin
                if (out_ready) begin
                    stalled = 1'b0;
                    if (sbq.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL extra_out: got %h expected no output at %0t", posit, $time);
                    end else begin
                        e = sbq.pop_front();
                        check("posit", 32'(posit), 32'(e));
                    end
                end else begin
                    stalled = 1'b1;
                    stall_val = posit;
                end
            end else begin
                stalled = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        apply(mk(0, 0, 0, 0, 0, 12'h000, 0, 0, 0, 1));
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_posit", 32'(posit), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        mode = 0;

        // first result with latency check
        send(mk(0, 0, 0, 0, 0, 12'h000, 0, 0, 0, 1), 16'h4000);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("latency_c1", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("latency_c2", 32'(out_valid), 32'd1);

        send(mk(1, 0, 0,   0, 0, 12'h000, 0, 0, 0, 1), 16'hC000);
        send(mk(0, 1, 1,   0, 0, 12'h000, 0, 0, 0, 1), 16'h8000);
        send(mk(0, 1, 0,   0, 0, 12'h000, 0, 0, 0, 1), 16'h0000);
        send(mk(0, 0, 0,  14, 0, 12'h000, 0, 0, 1, 0), 16'h7FFF);
        send(mk(0, 0, 0, -14, 0, 12'h000, 0, 0, 1, 0), 16'h0001);
        send(mk(1, 0, 0,  14, 0, 12'h000, 0, 0, 1, 0), 16'h8001);
        send(mk(0, 0, 0,   0, 0, 12'h001, 1, 0, 0, 1), 16'h4002);
        send(mk(0, 0, 0,   0, 0, 12'h000, 1, 0, 0, 1), 16'h4000);
        send(mk(0, 0, 0,   0, 0, 12'h000, 1, 1, 0, 1), 16'h4001);
        wait_drain();

        // back-to-back under alternating backpressure
        mode = 1;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            s = rand_stim();
            send(s, model(s));
        end
        wait_drain();

        mode = 2;
        for (int i = 0; i < 300; i++) begin
            s = rand_stim();
            send(s, model(s));
            if ($urandom_range(0, 5) == 0) idle_cycle();
        end
        wait_drain();

        // reset with two results in flight
        mode = 3;
        send(mk(0, 0, 0, 3, 1, 12'h0AB, 0, 0, 0, 1), 16'h0000);
        send(mk(1, 0, 0, -2, 0, 12'h155, 1, 1, 0, 1), 16'h0000);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("inflight_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        sbq.delete();
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_posit", 32'(posit), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mode = 0;
        s = rand_stim();
        s.nar = 1'b0;
        s.zero = 1'b0;
        send(s, model(s));
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
